// File: rtl/cdc_pkg.sv
// Shared types and widths for the request pacer: FSM states, operand/result
// widths and the packed request payload carried through the FIFO.
package cdc_pkg;

    localparam int OPW  = 4;
    localparam int RESW = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic            mode;
        logic [OPW-1:0]  a;
        logic [OPW-1:0]  b;
    } req_t;

endpackage

// File: rtl/cdc_req_fifo.sv
// Small request FIFO: power-of-two depth, wrapping pointers, explicit count.
// The head entry is visible combinationally so the pacer can register it on pop.
module cdc_req_fifo
    import cdc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_1,
    input  logic          rst_n,
    input  logic          push,
    input  req_t          push_data,
    input  logic          pop,
    output req_t          head,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    req_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Callers guarantee push only when not full and pop only when not empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_1) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/cdc_req_pacer.sv
// Buffers incoming requests and issues them as single-cycle pulses spaced at
// least GAP clk_1 edges apart, for a downstream clock-domain-crossing stage.
module cdc_req_pacer
    import cdc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 8
) (
    input  logic                         clk_1,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [OPW-1:0]               req_a,
    input  logic [OPW-1:0]               req_b,
    input  logic                         req_mode,
    output logic                         iss_valid,
    output logic [OPW-1:0]               iss_a,
    output logic [OPW-1:0]               iss_b,
    output logic                         iss_mode,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [RESW-1:0]              iss_total
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = $clog2(GAP);

    state_t          state_q, state_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            iss_valid_q;
    req_t            iss_req_q;
    logic [RESW-1:0] iss_total_q;

    logic            push;
    logic            pop;
    req_t            push_data;
    req_t            head;
    logic [CW-1:0]   count;

    assign req_ready = (count < CW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign push_data = '{mode: req_mode, a: req_a, b: req_b};

    cdc_req_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_1     (clk_1),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // An issue reloads the gap counter; the next issue waits for it to reach 0.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    gap_cnt_d = GW'(GAP - 1);
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end else if (count != '0) begin
                    pop       = 1'b1;
                    gap_cnt_d = GW'(GAP - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gap_cnt_q   <= '0;
            iss_valid_q <= 1'b0;
            iss_req_q   <= '0;
            iss_total_q <= '0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            iss_valid_q <= pop;
            if (pop) begin
                iss_req_q   <= head;
                iss_total_q <= iss_total_q + 1'b1;
            end
        end
    end

    assign iss_valid  = iss_valid_q;
    assign iss_a      = iss_req_q.a;
    assign iss_b      = iss_req_q.b;
    assign iss_mode   = iss_req_q.mode;
    assign fifo_count = count;
    assign iss_total  = iss_total_q;

endmodule

// File: tb/tb_cdc_req_pacer.sv
// Bench for cdc_req_pacer: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cdc_req_pacer;
    import cdc_pkg::*;

    localparam int DEPTH = 4;
    localparam int GAP   = 8;

    logic       clk_1     = 1'b0;
    logic       rst_n     = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_a     = '0;
    logic [3:0] req_b     = '0;
    logic       req_mode  = 1'b0;
    logic       iss_valid;
    logic [3:0] iss_a;
    logic [3:0] iss_b;
    logic       iss_mode;
    logic [2:0] fifo_count;
    logic [7:0] iss_total;

    int total_cnt = 0;
    int bad_cnt   = 0;

    cdc_req_pacer #(
        .DEPTH (DEPTH),
        .GAP   (GAP)
    ) dut (
        .clk_1      (clk_1),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_mode   (req_mode),
        .iss_valid  (iss_valid),
        .iss_a      (iss_a),
        .iss_b      (iss_b),
        .iss_mode   (iss_mode),
        .fifo_count (fifo_count),
        .iss_total  (iss_total)
    );

    initial forever #5 clk_1 = ~clk_1;

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference model: an issue happens on any edge where the queue is
    // non-empty and at least GAP edges have passed since the previous issue.
    req_t q[$];
    int   cyc        = 0;
    int   last_issue = -1000;
    logic m_valid    = 1'b0;
    req_t m_req      = '0;
    int   m_total    = 0;
    int   n_seen     = 0;

    task automatic model_reset();
        q.delete();
        last_issue = -1000;
        m_valid    = 1'b0;
        m_req      = '0;
        m_total    = 0;
    endtask

    task automatic model_step();
        bit   do_pop;
        bit   do_push;
        req_t r;
        cyc++;
        do_push = req_valid && (q.size() < DEPTH);
        do_pop  = (q.size() > 0) && (cyc - last_issue >= GAP);
        m_valid = 1'b0;
        if (do_pop) begin
            m_req      = q.pop_front();
            m_valid    = 1'b1;
            m_total    = (m_total + 1) % 256;
            last_issue = cyc;
        end
        if (do_push) begin
            r.mode = req_mode;
            r.a    = req_a;
            r.b    = req_b;
            q.push_back(r);
        end
    endtask

    initial forever begin
        @(posedge clk_1 or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
    end

    initial forever begin
        @(posedge clk_1);
        #1;
        chk("m_valid", int'(iss_valid), int'(m_valid));
        chk("m_count", int'(fifo_count), q.size());
        chk("m_ready", int'(req_ready), int'(q.size() < DEPTH));
        chk("m_total", int'(iss_total), m_total);
        chk("m_a", int'(iss_a), int'(m_req.a));
        chk("m_b", int'(iss_b), int'(m_req.b));
        chk("m_mode", int'(iss_mode), int'(m_req.mode));
        if (iss_valid) begin
            n_seen++;
            $display("issue %0d: a=%0d b=%0d mode=%0d total=%0d", n_seen, iss_a, iss_b, iss_mode, iss_total);
        end
    end

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic m);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        req_mode  = m;
    endtask

    initial begin
        int t;
        int peak;
        int n_acc;
        int n_iss;
        int iss_t[$];
        int iss_av[$];
        bit saw_full;
        bit acc;

        // Reset state
        repeat (3) tick();
        chk("rst_valid", int'(iss_valid), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_total", int'(iss_total), 0);
        chk("rst_ready", int'(req_ready), 1);
        rst_n = 1'b1;
        tick();

        // Single request: issued one edge after acceptance
        drive(1'b1, 4'd3, 4'd5, 1'b0);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        chk("s1_acc_valid", int'(iss_valid), 0);
        chk("s1_acc_count", int'(fifo_count), 1);
        tick();
        chk("s1_valid", int'(iss_valid), 1);
        chk("s1_a", int'(iss_a), 3);
        chk("s1_b", int'(iss_b), 5);
        chk("s1_mode", int'(iss_mode), 0);
        chk("s1_total", int'(iss_total), 1);
        chk("s1_count", int'(fifo_count), 0);
        tick();
        chk("s1_pulse_end", int'(iss_valid), 0);
        repeat (10) tick();

        // Four consecutive pushes: pulses exactly GAP apart, in order
        peak = 0;
        t    = 0;
        for (int i = 0; i < 44; i++) begin
            if (i < 4) drive(1'b1, 4'(i + 1), 4'(i + 9), 1'(i));
            else       drive(1'b0, 4'd0, 4'd0, 1'b0);
            tick();
            t++;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (iss_valid) begin
                iss_t.push_back(t);
                iss_av.push_back(int'(iss_a));
            end
        end
        chk("s2_issues", iss_t.size(), 4);
        chk("s2_peak", peak, 3);
        for (int i = 0; i < iss_t.size() && i < 4; i++) begin
            chk("s2_order", iss_av[i], i + 1);
            if (i > 0) chk("s2_spacing", iss_t[i] - iss_t[i-1], GAP);
        end

        // Stall in WAIT, then offer five requests back-to-back
        iss_av.delete();
        drive(1'b1, 4'hA, 4'h1, 1'b1);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        tick();
        if (iss_valid) iss_av.push_back(int'(iss_a));
        n_acc    = 0;
        saw_full = 1'b0;
        for (int i = 0; i < 80 && n_acc < 5; i++) begin
            drive(1'b1, 4'(n_acc + 5), 4'(n_acc), 1'b0);
            acc = req_ready;
            tick();
            if (acc) n_acc++;
            if (iss_valid) iss_av.push_back(int'(iss_a));
            if (fifo_count == 3'd4) begin
                saw_full = 1'b1;
                chk("s3_ready_full", int'(req_ready), 0);
            end
        end
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        chk("s3_accepted", n_acc, 5);
        chk("s3_full_seen", int'(saw_full), 1);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (iss_valid) iss_av.push_back(int'(iss_a));
        end
        chk("s3_issues", iss_av.size(), 6);
        if (iss_av.size() == 6) begin
            chk("s3_first", iss_av[0], 10);
            for (int i = 1; i < 6; i++) chk("s3_order", iss_av[i], i + 4);
        end
        repeat (10) tick();

        // Same-edge push and pop at count 2
        drive(1'b1, 4'd1, 4'd1, 1'b0); tick();
        drive(1'b1, 4'd2, 4'd2, 1'b0); tick();
        drive(1'b1, 4'd3, 4'd3, 1'b0); tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        chk("s4_pre_count", int'(fifo_count), 2);
        repeat (6) tick();
        chk("s4_pre_valid", int'(iss_valid), 0);
        drive(1'b1, 4'd4, 4'd4, 1'b0);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        chk("s4_count", int'(fifo_count), 2);
        chk("s4_valid", int'(iss_valid), 1);
        chk("s4_oldest", int'(iss_a), 2);
        repeat (30) tick();

        // Reset in WAIT with three queued, right on an issue cycle
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'(i + 11), 4'(i), 1'b1);
            tick();
        end
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        repeat (5) tick();
        chk("s5_pre_valid", int'(iss_valid), 1);
        chk("s5_pre_count", int'(fifo_count), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_valid", int'(iss_valid), 0);
        chk("s5_count", int'(fifo_count), 0);
        chk("s5_total", int'(iss_total), 0);
        chk("s5_ready", int'(req_ready), 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        drive(1'b1, 4'd7, 4'd2, 1'b1);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        chk("s5_acc_valid", int'(iss_valid), 0);
        tick();
        chk("s5_valid_after", int'(iss_valid), 1);
        chk("s5_a_after", int'(iss_a), 7);
        chk("s5_b_after", int'(iss_b), 2);
        chk("s5_mode_after", int'(iss_mode), 1);
        chk("s5_total_after", int'(iss_total), 1);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom), 1'($urandom));
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        drive(1'b0, 4'd0, 4'd0, 1'b0);

        // 256 issues wrap the issue counter
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_iss = 0;
        for (int i = 0; i < 2600 && n_iss < 256; i++) begin
            drive(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
            tick();
            if (iss_valid) begin
                n_iss++;
                if (n_iss == 255) chk("s6_total_255", int'(iss_total), 255);
            end
        end
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        chk("s6_issues", n_iss, 256);
        chk("s6_wrap", int'(iss_total), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
